me_stage_ctrl: RTL and testbench

//  Memory-access stage of the 5-stage MIPS pipeline; consumes the EX/ME register bundle.

---
 rtl/me_pkg.sv | 17 +
 rtl/me_timeout_cnt.sv | 22 ++
 rtl/me_stage_ctrl.sv | 126 ++++++++++++
 tb/tb_me_stage_ctrl.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/me_pkg.sv
// Shared types and constants for the memory-access pipeline stage.
package me_pkg;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 5;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  // Memory operation captured when an access is launched
  typedef struct packed {
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [REG_W-1:0]  dest;
    logic              regwr;
    logic              we;
  } mem_op_t;
endpackage

// File: rtl/me_timeout_cnt.sv
// Clear/enable cycle counter flagging the last permitted WAIT cycle.
module me_timeout_cnt #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc_c
);
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     cnt_q <= '0;
    else if (clr) cnt_q <= '0;
    else if (en)  cnt_q <= cnt_q + CNT_W'(1);
  end

  assign tc_c = (cnt_q == CNT_W'(TIMEOUT - 1));
endmodule

// File: rtl/me_stage_ctrl.sv
// MIPS memory-access stage: data-memory req/ack handshake, upstream stall, ME/WB register.
module me_stage_ctrl
  import me_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] ex_alu,
  input  logic [DATA_W-1:0] ex_wdata,
  input  logic [REG_W-1:0]  ex_dest,
  input  logic              ex_mem2reg,
  input  logic              ex_memwr,
  input  logic              ex_regwr,
  output logic              stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_data,
  output logic [REG_W-1:0]  wb_dest,
  output logic              wb_regwr,
  output logic              mem_err
);
  logic [0:0]        state_q, state_d;
  mem_op_t           op_q, op_d;
  logic              wb_valid_d, wb_regwr_d, err_d;
  logic [DATA_W-1:0] wb_data_d;
  logic [REG_W-1:0]  wb_dest_d;
  logic              mem_op_c, tmo_c;

  assign mem_op_c = ex_valid & (ex_mem2reg | ex_memwr);

  me_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk  (clk),
    .rst  (rst),
    .clr  (state_q == ST_IDLE),
    .en   ((state_q == ST_WAIT) & ~dmem_ack),
    .tc_c (tmo_c)
  );

  // Request is asserted exactly while an access is outstanding
  assign dmem_req   = (state_q == ST_WAIT);
  assign dmem_we    = op_q.we;
  assign dmem_addr  = op_q.addr;
  assign dmem_wdata = op_q.wdata;
  assign stall      = (state_q == ST_WAIT) & ~dmem_ack;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      wb_valid <= 1'b0;
      wb_data  <= '0;
      wb_dest  <= '0;
      wb_regwr <= 1'b0;
      mem_err  <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      wb_valid <= wb_valid_d;
      wb_data  <= wb_data_d;
      wb_dest  <= wb_dest_d;
      wb_regwr <= wb_regwr_d;
      mem_err  <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    wb_valid_d = 1'b0;
    wb_data_d  = wb_data;
    wb_dest_d  = wb_dest;
    wb_regwr_d = wb_regwr;
    err_d      = mem_err;
    case (state_q)
      ST_IDLE: begin
        if (ex_valid && !mem_op_c) begin
          wb_valid_d = 1'b1;
          wb_data_d  = ex_alu;
          wb_dest_d  = ex_dest;
          wb_regwr_d = ex_regwr;
        end else if (mem_op_c && (ex_alu[1:0] != 2'b00)) begin
          err_d      = 1'b1;
          wb_valid_d = 1'b1;
          wb_data_d  = ex_alu;
          wb_dest_d  = ex_dest;
          wb_regwr_d = 1'b0;
        end else if (mem_op_c) begin
          op_d.addr  = ex_alu;
          op_d.wdata = ex_wdata;
          op_d.dest  = ex_dest;
          op_d.regwr = ex_regwr;
          op_d.we    = ex_memwr;
          state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Ack takes precedence over a timeout in the same cycle
        if (dmem_ack) begin
          state_d    = ST_IDLE;
          wb_valid_d = 1'b1;
          wb_dest_d  = op_q.dest;
          if (op_q.we) begin
            wb_regwr_d = 1'b0;
          end else begin
            wb_data_d  = dmem_rdata;
            wb_regwr_d = op_q.regwr;
          end
        end else if (tmo_c) begin
          state_d    = ST_IDLE;
          err_d      = 1'b1;
          wb_valid_d = 1'b1;
          wb_dest_d  = op_q.dest;
          wb_regwr_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end
endmodule

// File: tb/tb_me_stage_ctrl.sv
// Directed bench for me_stage_ctrl: ALU pass-through, load/store handshakes, misalignment, timeout, reset.
module tb_me_stage_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_mem2reg, ex_memwr, ex_regwr;
  logic [31:0] ex_alu, ex_wdata;
  logic [4:0]  ex_dest;
  logic        stall, dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        wb_valid, wb_regwr, mem_err;
  logic [31:0] wb_data;
  logic [4:0]  wb_dest;

  int total = 0;
  int bad   = 0;

  me_stage_ctrl #(.TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_alu(ex_alu), .ex_wdata(ex_wdata), .ex_dest(ex_dest),
    .ex_mem2reg(ex_mem2reg), .ex_memwr(ex_memwr), .ex_regwr(ex_regwr),
    .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_dest(wb_dest), .wb_regwr(wb_regwr),
    .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are driven and outputs sampled here
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic bundle(input logic v, input logic [31:0] alu, input logic [31:0] wd,
                        input logic [4:0] d, input logic ld, input logic st, input logic rw);
    ex_valid = v; ex_alu = alu; ex_wdata = wd; ex_dest = d;
    ex_mem2reg = ld; ex_memwr = st; ex_regwr = rw;
  endtask

  initial begin
    rst = 1'b0;
    dmem_ack = 1'b0; dmem_rdata = '0;
    bundle(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    #12;
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_req",      32'(dmem_req), 32'd0);
    chk("rst_err",      32'(mem_err),  32'd0);
    chk("rst_stall",    32'(stall),    32'd0);
    rst = 1'b1;
    step();

    // Non-memory op: latency 1, never stalls
    bundle(1'b1, 32'h1234, 32'h0, 5'd5, 1'b0, 1'b0, 1'b1);
    #1 chk("alu_stall", 32'(stall), 32'd0);
    step();
    chk("alu_wb_valid", 32'(wb_valid), 32'd1);
    chk("alu_wb_data",  wb_data,       32'h1234);
    chk("alu_wb_dest",  32'(wb_dest),  32'd5);
    chk("alu_wb_regwr", 32'(wb_regwr), 32'd1);
    bundle(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    step();
    chk("alu_pulse", 32'(wb_valid), 32'd0);

    // Load 0x40, three stalled cycles, ack on the fourth
    bundle(1'b1, 32'h40, 32'h0, 5'd7, 1'b1, 1'b0, 1'b1);
    step();
    chk("ld_req",      32'(dmem_req), 32'd1);
    chk("ld_we",       32'(dmem_we),  32'd0);
    chk("ld_addr",     dmem_addr,     32'h40);
    chk("ld_wb_valid", 32'(wb_valid), 32'd0);
    bundle(1'b1, 32'h99, 32'h0, 5'd9, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1 chk($sformatf("ld_stall%0d", i), 32'(stall), 32'd1);
      chk($sformatf("ld_addr%0d", i), dmem_addr, 32'h40);
      step();
    end
    dmem_ack = 1'b1; dmem_rdata = 32'hDEADBEEF;
    #1 chk("ld_ack_stall", 32'(stall), 32'd0);
    step();
    dmem_ack = 1'b0; dmem_rdata = '0;
    chk("ld_wb_valid2", 32'(wb_valid), 32'd1);
    chk("ld_wb_data",   wb_data,       32'hDEADBEEF);
    chk("ld_wb_regwr",  32'(wb_regwr), 32'd1);
    chk("ld_wb_dest",   32'(wb_dest),  32'd7);
    chk("ld_req_drop",  32'(dmem_req), 32'd0);
    // Bundle presented during the ack cycle is accepted one cycle later
    step();
    chk("held_wb_data", wb_data,      32'h99);
    chk("held_wb_dest", 32'(wb_dest), 32'd9);
    bundle(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    step();

    // Store 0x80, ack after one stalled cycle; outputs hold while upstream changes
    bundle(1'b1, 32'h80, 32'hA5A5A5A5, 5'd3, 1'b0, 1'b1, 1'b1);
    step();
    chk("st_req",   32'(dmem_req), 32'd1);
    chk("st_we",    32'(dmem_we),  32'd1);
    chk("st_addr",  dmem_addr,     32'h80);
    chk("st_wdata", dmem_wdata,    32'hA5A5A5A5);
    bundle(1'b0, 32'hFFFFFFF0, 32'h12345678, 5'd0, 1'b0, 1'b0, 1'b0);
    #1 chk("st_stall", 32'(stall), 32'd1);
    step();
    chk("st_addr_hold",  dmem_addr,  32'h80);
    chk("st_wdata_hold", dmem_wdata, 32'hA5A5A5A5);
    dmem_ack = 1'b1;
    step();
    dmem_ack = 1'b0;
    chk("st_wb_valid", 32'(wb_valid), 32'd1);
    chk("st_wb_regwr", 32'(wb_regwr), 32'd0);
    chk("st_req_drop", 32'(dmem_req), 32'd0);
    chk("st_no_err",   32'(mem_err),  32'd0);

    // Ack on the final (15th) WAIT cycle completes normally
    bundle(1'b1, 32'h100, 32'h0, 5'd4, 1'b1, 1'b0, 1'b1);
    step();
    bundle(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 14; i++) step();
    chk("late_req", 32'(dmem_req), 32'd1);
    dmem_ack = 1'b1; dmem_rdata = 32'h11;
    step();
    dmem_ack = 1'b0;
    chk("late_wb_data",  wb_data,       32'h11);
    chk("late_wb_regwr", 32'(wb_regwr), 32'd1);
    chk("late_no_err",   32'(mem_err),  32'd0);

    // No ack for 15 WAIT cycles aborts the access
    bundle(1'b1, 32'h200, 32'h0, 5'd6, 1'b1, 1'b0, 1'b1);
    step();
    bundle(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 14; i++) step();
    chk("tmo_req_before", 32'(dmem_req), 32'd1);
    chk("tmo_stall_before", 32'(stall), 32'd1);
    step();
    chk("tmo_req",      32'(dmem_req), 32'd0);
    chk("tmo_err",      32'(mem_err),  32'd1);
    chk("tmo_wb_valid", 32'(wb_valid), 32'd1);
    chk("tmo_wb_regwr", 32'(wb_regwr), 32'd0);
    chk("tmo_stall",    32'(stall),    32'd0);

    // Reset during an outstanding request clears everything at once
    bundle(1'b1, 32'h300, 32'h0, 5'd2, 1'b1, 1'b0, 1'b1);
    step();
    chk("pre_rst_req", 32'(dmem_req), 32'd1);
    rst = 1'b0;
    #1;
    chk("mid_rst_req",      32'(dmem_req), 32'd0);
    chk("mid_rst_stall",    32'(stall),    32'd0);
    chk("mid_rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("mid_rst_err",      32'(mem_err),  32'd0);
    bundle(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    #3 rst = 1'b1;
    step();

    // Misaligned load: no access, sticky error
    bundle(1'b1, 32'h42, 32'h0, 5'd8, 1'b1, 1'b0, 1'b1);
    step();
    chk("mis_req",      32'(dmem_req), 32'd0);
    chk("mis_err",      32'(mem_err),  32'd1);
    chk("mis_wb_valid", 32'(wb_valid), 32'd1);
    chk("mis_wb_regwr", 32'(wb_regwr), 32'd0);
    chk("mis_stall",    32'(stall),    32'd0);

    // Stray ack while idle is ignored; error stays sticky
    bundle(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    dmem_ack = 1'b1; dmem_rdata = 32'hCAFE0000;
    step();
    dmem_ack = 1'b0;
    chk("idle_ack_wb_valid", 32'(wb_valid), 32'd0);
    chk("idle_ack_req",      32'(dmem_req), 32'd0);
    chk("err_sticky",        32'(mem_err),  32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
